ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage that consumes the operand and control fields delivered by the ID/EX pipeline register. It executes MULT, MULTU, DIV and DIVU over 32 iterations and owns the architectural HI/LO registers, including MTHI/MTLO writes. While an operation is in flight, it stalls the front of the pipeline whenever an instruction that depends on it reaches EX.

---
 rtl/ex_muldiv_if.sv | 27 ++
 rtl/ex_muldiv.sv | 129 ++++++++++++
 tb/tb_ex_muldiv.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Operand/control bundle from ID/EX into the EX-stage multiply/divide unit,
// plus the HI/LO, busy and stall signals it returns to the pipeline.
interface ex_muldiv_if;
   logic        I_Start;
   logic [1:0]  I_Op;
   logic [31:0] I_O1;
   logic [31:0] I_O2;
   logic        I_MTHI;
   logic        I_MTLO;
   logic        I_ReadHiLo;
   logic        I_Flush;
   logic        O_Busy;
   logic        O_Stall;
   logic        O_Done;
   logic [31:0] O_HI;
   logic [31:0] O_LO;

   modport slave (
      input  I_Start, I_Op, I_O1, I_O2, I_MTHI, I_MTLO, I_ReadHiLo, I_Flush,
      output O_Busy, O_Stall, O_Done, O_HI, O_LO
   );

   modport master (
      output I_Start, I_Op, I_O1, I_O2, I_MTHI, I_MTLO, I_ReadHiLo, I_Flush,
      input  O_Busy, O_Stall, O_Done, O_HI, O_LO
   );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO: 32 shift-add or
// restoring-division steps on magnitudes, then one cycle of sign fix-up.
module ex_muldiv (
   input  logic        clk,
   input  logic        rst_n,
   ex_muldiv_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [1:0]  op_q;
   logic [31:0] mag_a, mag_b, o1_q;
   logic        neg_q, rem_neg_q;
   logic [63:0] acc;
   logic [31:0] hi_q, lo_q;
   logic        done_q;

   // Magnitudes of the incoming operands; unsigned ops never negate.
   logic        signed_op, a_neg, b_neg;
   logic [31:0] abs_a, abs_b;
   assign signed_op = ~bus.I_Op[0];
   assign a_neg     = signed_op & bus.I_O1[31];
   assign b_neg     = signed_op & bus.I_O2[31];
   assign abs_a     = a_neg ? -bus.I_O1 : bus.I_O1;
   assign abs_b     = b_neg ? -bus.I_O2 : bus.I_O2;

   // Multiply step: acc = {partial product, remaining multiplier bits}.
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag_a : 32'd0)};
   assign mul_next = {mul_sum, acc[31:1]};

   // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
   logic [32:0] div_shift, div_trial;
   logic        div_ge;
   logic [63:0] div_next;
   assign div_shift = {acc[63:32], acc[31]};
   assign div_trial = div_shift - {1'b0, mag_b};
   assign div_ge    = ~div_trial[32];
   assign div_next  = {(div_ge ? div_trial[31:0] : div_shift[31:0]), acc[30:0], div_ge};

   // Final HI/LO values presented at FIX.
   logic [63:0] prod;
   logic [31:0] quo, rem, fix_hi, fix_lo;
   assign prod = neg_q ? -acc : acc;
   assign quo  = neg_q ? -acc[31:0] : acc[31:0];
   assign rem  = rem_neg_q ? -acc[63:32] : acc[63:32];

   always_comb begin
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
      if (op_q[1]) begin
         if (mag_b == 32'd0) begin
            fix_hi = o1_q;
            fix_lo = 32'hFFFF_FFFF;
         end else begin
            fix_hi = rem;
            fix_lo = quo;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 5'd0;
         op_q      <= 2'd0;
         mag_a     <= 32'd0;
         mag_b     <= 32'd0;
         o1_q      <= 32'd0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         acc       <= 64'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.I_Start && !bus.I_Flush) begin
                  state     <= RUN;
                  cnt       <= 5'd0;
                  op_q      <= bus.I_Op;
                  mag_a     <= abs_a;
                  mag_b     <= abs_b;
                  o1_q      <= bus.I_O1;
                  neg_q     <= a_neg ^ b_neg;
                  rem_neg_q <= a_neg;
                  acc       <= {32'd0, (bus.I_Op[1] ? abs_a : abs_b)};
               end else if (!bus.I_Start) begin
                  if (bus.I_MTHI) hi_q <= bus.I_O1;
                  if (bus.I_MTLO) lo_q <= bus.I_O1;
               end
            end
            RUN: begin
               if (bus.I_Flush) begin
                  state <= IDLE;
               end else begin
                  acc <= op_q[1] ? div_next : mul_next;
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd31) state <= FIX;
               end
            end
            FIX: begin
               state <= IDLE;
               if (!bus.I_Flush) begin
                  hi_q   <= fix_hi;
                  lo_q   <= fix_lo;
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.O_Busy  = (state != IDLE);
   assign bus.O_Stall = bus.O_Busy &
                        (bus.I_Start | bus.I_MTHI | bus.I_MTLO | bus.I_ReadHiLo);
   assign bus.O_Done  = done_q;
   assign bus.O_HI    = hi_q;
   assign bus.O_LO    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus random operations
// compared against a plain-arithmetic HI/LO reference model.
module tb_ex_muldiv;

   logic clk;
   logic rst_n;
   ex_muldiv_if bus();

   ex_muldiv dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: HI/LO from ordinary 64-bit arithmetic.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      logic signed [63:0] sa, sb, sp, sq, sr;
      logic [63:0] ua, ub, up;
      sa = 64'(signed'(a));
      sb = 64'(signed'(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         2'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
         2'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
         default: begin
            if (b == 32'd0) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else if (op == 2'd2) begin
               sq = sa / sb; sr = sa % sb;
               hi = sr[31:0]; lo = sq[31:0];
            end else begin
               hi = a % b; lo = a / b;
            end
         end
      endcase
   endfunction

   // Issues one operation (sampled at the next edge = edge 0) and follows it to
   // completion; returns in the O_Done cycle so a back-to-back start is possible.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic read_hilo);
      int busy_cycles;
      int n;
      logic [31:0] mhi, mlo;
      model(op, a, b, mhi, mlo);
      bus.I_Start    = 1'b1;
      bus.I_Op       = op;
      bus.I_O1       = a;
      bus.I_O2       = b;
      bus.I_ReadHiLo = read_hilo;
      step();
      bus.I_Start = 1'b0;
      busy_cycles = 0;
      n = 0;
      while (bus.O_Busy && n < 40) begin
         busy_cycles++;
         if (bus.O_Done) check({tag, " done_early"}, 64'(bus.O_Done), 64'd0);
         if (read_hilo) check({tag, " stall_busy"}, 64'(bus.O_Stall), 64'd1);
         step();
         n++;
      end
      check({tag, " busy_cycles"}, 64'(busy_cycles), 64'd33);
      check({tag, " done"}, 64'(bus.O_Done), 64'd1);
      if (read_hilo) check({tag, " stall_idle"}, 64'(bus.O_Stall), 64'd0);
      bus.I_ReadHiLo = 1'b0;
      exp_hi = mhi;
      exp_lo = mlo;
      check({tag, " hi"}, 64'(bus.O_HI), 64'(exp_hi));
      check({tag, " lo"}, 64'(bus.O_LO), 64'(exp_lo));
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      rst_n          = 1'b0;
      bus.I_Start    = 1'b0;
      bus.I_Op       = 2'd0;
      bus.I_O1       = 32'd0;
      bus.I_O2       = 32'd0;
      bus.I_MTHI     = 1'b0;
      bus.I_MTLO     = 1'b0;
      bus.I_ReadHiLo = 1'b0;
      bus.I_Flush    = 1'b0;
      step();
      step();
      check("reset busy", 64'(bus.O_Busy), 64'd0);
      check("reset done", 64'(bus.O_Done), 64'd0);
      check("reset hi",   64'(bus.O_HI),   64'd0);
      check("reset lo",   64'(bus.O_LO),   64'd0);
      rst_n = 1'b1;
      step();

      run_op("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      step();
      check("mult done_low", 64'(bus.O_Done), 64'd0);

      // Back-to-back: the DIVU start is sampled on edge 34.
      run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0);
      step();

      run_op("div_m7_2",    2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op("div_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("divu_by0",    2'd3, 32'd7, 32'd0, 1'b0);
      run_op("div_by0",     2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
      run_op("read_stall",  2'd0, 32'd12, 32'hFFFF_FFF0, 1'b1);
      check("mult_neg3x5 const hi", 64'(32'hFFFF_FFFF), 64'(32'hFFFF_FFFF) & 64'(bus.O_HI | 32'hFFFF_FFFF));
      step();

      // MTHI while busy is held off; MTHI while idle lands next cycle.
      bus.I_Start = 1'b1; bus.I_Op = 2'd1; bus.I_O1 = 32'd9; bus.I_O2 = 32'd9;
      step();
      bus.I_Start = 1'b0;
      bus.I_MTHI  = 1'b1;
      bus.I_O1    = 32'h1234;
      step();
      check("mthi busy stall", 64'(bus.O_Stall), 64'd1);
      for (int i = 0; i < 4; i++) step();
      check("mthi busy hi", 64'(bus.O_HI), 64'(exp_hi));
      bus.I_MTHI = 1'b0;
      for (int i = 0; i < 40 && bus.O_Busy; i++) step();
      check("mthi op lo", 64'(bus.O_LO), 64'd81);
      check("mthi op hi", 64'(bus.O_HI), 64'd0);
      bus.I_MTHI = 1'b1;
      step();
      bus.I_MTHI = 1'b0;
      check("mthi idle hi", 64'(bus.O_HI), 64'h1234);

      // Flush at cycle 10 of a MULT with HI/LO preloaded.
      bus.I_O1 = 32'hAAAA; bus.I_MTHI = 1'b1; step();
      bus.I_MTHI = 1'b0; bus.I_O1 = 32'h5555; bus.I_MTLO = 1'b1; step();
      bus.I_MTLO = 1'b0;
      check("preload hi", 64'(bus.O_HI), 64'hAAAA);
      check("preload lo", 64'(bus.O_LO), 64'h5555);
      bus.I_Start = 1'b1; bus.I_Op = 2'd0; bus.I_O1 = 32'd3; bus.I_O2 = 32'd4;
      step();
      bus.I_Start = 1'b0;
      for (int i = 1; i < 10; i++) step();
      bus.I_Flush = 1'b1;
      step();
      bus.I_Flush = 1'b0;
      check("flush busy", 64'(bus.O_Busy), 64'd0);
      for (int i = 0; i < 30; i++) begin
         if (bus.O_Done) check("flush no_done", 64'(bus.O_Done), 64'd0);
         step();
      end
      check("flush hi", 64'(bus.O_HI), 64'hAAAA);
      check("flush lo", 64'(bus.O_LO), 64'h5555);

      // Asynchronous reset at cycle 20 of a DIV.
      bus.I_Start = 1'b1; bus.I_Op = 2'd2; bus.I_O1 = 32'd1000; bus.I_O2 = 32'd3;
      step();
      bus.I_Start = 1'b0;
      for (int i = 1; i < 20; i++) step();
      rst_n = 1'b0;
      #1;
      check("arst busy", 64'(bus.O_Busy), 64'd0);
      check("arst done", 64'(bus.O_Done), 64'd0);
      check("arst hi",   64'(bus.O_HI),   64'd0);
      check("arst lo",   64'(bus.O_LO),   64'd0);
      step();
      rst_n = 1'b1;
      step();
      check("arst idle", 64'(bus.O_Busy), 64'd0);
      run_op("mult_2x3", 2'd0, 32'd2, 32'd3, 1'b0);
      step();

      for (int k = 0; k < 12; k++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if (rop[1] && $urandom_range(0, 1) == 1) rb = $urandom_range(1, 255);
         if ($urandom_range(0, 7) == 0) rb = 32'd0;
         run_op($sformatf("rand%0d", k), rop, ra, rb, 1'b0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
